// File: rtl/apb_ram_pkg.sv
// Shared types and constants for the APB RAM slave: FSM state encoding and wait counter width.
package apb_ram_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam int CNT_W = 4;

endpackage

// File: rtl/apb_ram_if.sv
// APB bus bundle between a master and the RAM slave.
// Handshake: a transfer is requested while psel=1 and penable=1; the master holds all request
// fields stable until the single cycle in which pready=1, which completes it (pslverr and prdata
// are qualified by pready). Dropping psel before pready abandons the transfer.
interface apb_ram_if #(
  parameter int DATA_W = 32
);
  logic [31:0]         paddr;
  logic                psel;
  logic                penable;
  logic                pwrite;
  logic [DATA_W-1:0]   pwdata;
  logic [DATA_W/8-1:0] pstrb;
  logic [DATA_W-1:0]   prdata;
  logic                pready;
  logic                pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_ram_core.sv
// Word-addressed RAM with per-byte write enables and an asynchronous read port; no reset on contents.
module apb_ram_core #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                pclk,
  input  logic [DATA_W/8-1:0] we,
  input  logic [AW-1:0]       waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [AW-1:0]       raddr,
  output logic [DATA_W-1:0]   rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge pclk) begin
    for (int i = 0; i < DATA_W/8; i++) begin
      if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/apb_ram_slave.sv
// APB RAM slave with optional wait states; byte strobes honoured only when APB_RAM_PSTRB_EN is defined.
module apb_ram_slave
  import apb_ram_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 0
) (
  input  logic   pclk,
  input  logic   presetn,
  apb_ram_if.slave bus,
  output state_e state_dbg
);
  localparam int          BYTES      = DATA_W/8;
  localparam int          AW         = $clog2(DEPTH);
  localparam int          OFF_W      = $clog2(BYTES);
  localparam logic [31:0] LIMIT      = 32'(DEPTH*BYTES);
  localparam logic [31:0] ALIGN_MASK = 32'(BYTES-1);

  state_e             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               start;

  logic [AW-1:0]      req_idx;
  logic               req_write, req_err;
  logic [DATA_W-1:0]  req_wdata;
  logic [BYTES-1:0]   req_strb;

  logic               live_err;
  logic [AW-1:0]      live_idx;
  logic [BYTES-1:0]   live_strb;

  logic               cur_err, cur_write;
  logic [AW-1:0]      rd_idx;
  logic [DATA_W-1:0]  mem_rdata;
  logic [BYTES-1:0]   mem_we;

  logic               pready_q, pslverr_q;
  logic [DATA_W-1:0]  prdata_q;

  assign live_err = (bus.paddr >= LIMIT) || ((bus.paddr & ALIGN_MASK) != 32'd0);
  assign live_idx = AW'(bus.paddr >> OFF_W);
`ifdef APB_RAM_PSTRB_EN
  assign live_strb = bus.pstrb;
`else
  assign live_strb = '1;
`endif

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    start   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.psel && bus.penable) begin
          start = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_n = S_RESP;
          end else begin
            state_n = S_WAIT;
            cnt_n   = CNT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      S_WAIT: begin
        // Losing psel mid-wait abandons the transfer before anything is committed.
        if (!bus.psel) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else if (cnt == '0) begin
          state_n = S_RESP;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      req_idx   <= '0;
      req_write <= 1'b0;
      req_err   <= 1'b0;
      req_wdata <= '0;
      req_strb  <= '0;
    end else if (start) begin
      req_idx   <= live_idx;
      req_write <= bus.pwrite;
      req_err   <= live_err;
      req_wdata <= bus.pwdata;
      req_strb  <= live_strb;
    end
  end

  // With no wait states the response is built from the live bus in the same edge as the capture.
  assign cur_err   = start ? live_err   : req_err;
  assign cur_write = start ? bus.pwrite : req_write;
  assign rd_idx    = start ? live_idx   : req_idx;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      pready_q  <= (state_n == S_RESP);
      pslverr_q <= (state_n == S_RESP) && cur_err;
      prdata_q  <= ((state_n == S_RESP) && !cur_err && !cur_write) ? mem_rdata : '0;
    end
  end

  assign mem_we = ((state == S_RESP) && req_write && !req_err) ? req_strb : '0;

  apb_ram_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_core (
    .pclk  (pclk),
    .we    (mem_we),
    .waddr (req_idx),
    .wdata (req_wdata),
    .raddr (rd_idx),
    .rdata (mem_rdata)
  );

  assign bus.prdata  = prdata_q;
  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;
  assign state_dbg   = state;
endmodule

// File: tb/tb_apb_ram_slave.sv
// Bench for apb_ram_slave: one zero-wait and one 3-wait instance against a transaction-level RAM model.
module tb_apb_ram_slave;
  import apb_ram_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 64;

  // ---------------- clock / reset ----------------
  logic pclk    = 1'b0;
  logic presetn = 1'b0;
  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  apb_ram_if #(.DATA_W(DW)) bus0 ();
  apb_ram_if #(.DATA_W(DW)) bus1 ();
  state_e st0, st1;

  apb_ram_slave #(.DATA_W(DW), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .pclk(pclk), .presetn(presetn), .bus(bus0.slave), .state_dbg(st0));
  apb_ram_slave #(.DATA_W(DW), .DEPTH(DEPTH), .WAIT_CYCLES(3)) dut1 (
    .pclk(pclk), .presetn(presetn), .bus(bus1.slave), .state_dbg(st1));

  // ---------------- model ----------------
  logic [31:0] model_mem [2][DEPTH];
  int          exp_cyc  [2] = '{-1, -1};
  logic        exp_err  [2];
  logic        exp_isrd [2];
  logic [31:0] exp_data [2];
  logic [31:0] exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic int wait_of(int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic logic addr_bad(logic [31:0] a);
    return (a >= 32'(DEPTH*4)) || (a[1:0] != 2'b00);
  endfunction

  task automatic model_write(int d, int idx, logic [31:0] data, logic [3:0] strb);
    for (int b = 0; b < 4; b++) begin
      bit en;
`ifdef APB_RAM_PSTRB_EN
      en = strb[b];
`else
      en = 1'b1;
`endif
      if (en) model_mem[d][idx][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(int d, logic sel, logic en, logic wr, logic [31:0] addr,
                         logic [31:0] data, logic [3:0] strb);
    if (d == 0) begin
      bus0.psel = sel; bus0.penable = en; bus0.pwrite = wr;
      bus0.paddr = addr; bus0.pwdata = data; bus0.pstrb = strb;
    end else begin
      bus1.psel = sel; bus1.penable = en; bus1.pwrite = wr;
      bus1.paddr = addr; bus1.pwdata = data; bus1.pstrb = strb;
    end
  endtask

  task automatic get_out(int d, output logic rdy, output logic err, output logic [31:0] rd);
    if (d == 0) begin rdy = bus0.pready; err = bus0.pslverr; rd = bus0.prdata; end
    else        begin rdy = bus1.pready; err = bus1.pslverr; rd = bus1.prdata; end
  endtask

  task automatic go_idle(int d);
    @(posedge pclk); #1;
    set_req(d, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
  endtask

  // One full APB transfer; the next call's setup phase follows RESP directly (back-to-back).
  task automatic xfer(int d, logic wr, logic [31:0] addr, logic [31:0] data, logic [3:0] strb,
                      bit scramble, output logic [31:0] rdata, output logic err, output int lat);
    int   acc;
    int   setup_len;
    logic rdy;
    logic bad;
    setup_len = $urandom_range(1, 2);
    bad = addr_bad(addr);
    @(posedge pclk); #1;
    set_req(d, 1'b1, 1'b0, wr, addr, data, strb);
    repeat (setup_len - 1) begin @(posedge pclk); #1; end
    @(posedge pclk); #1;
    set_req(d, 1'b1, 1'b1, wr, addr, data, strb);
    acc = cyc;
    exp_err[d]  = bad;
    exp_isrd[d] = !wr;
    exp_data[d] = bad ? 32'd0 : model_mem[d][addr[7:2]];
    exp_cyc[d]  = acc + 1 + wait_of(d);
    if (wr && !bad) model_write(d, int'(addr[7:2]), data, strb);
    lat = -1; rdata = '0; err = 1'b0; rdy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge pclk);
      get_out(d, rdy, err, rdata);
      if (rdy) begin lat = cyc - acc; break; end
      if (scramble && cyc > acc)
        set_req(d, 1'b1, 1'b1, wr, {24'd0, 6'($urandom_range(0, DEPTH-1)), 2'b00},
                $urandom, 4'($urandom));
    end
    if (lat < 0) begin
      n_checks++;
      $display("FAIL dut%0d_timeout: no pready within 40 cycles, required latency %0d",
               d, 1 + wait_of(d));
    end
  endtask

  task automatic rand_xfer(int d, bit scramble);
    logic [31:0] a, rd;
    logic        e;
    int          l;
    int          pick;
    pick = $urandom_range(0, 9);
    if (pick < 7)      a = {24'd0, 6'($urandom_range(0, DEPTH-1)), 2'b00};
    else if (pick < 8) a = {24'd0, 6'($urandom_range(0, DEPTH-1)), 2'($urandom_range(1, 3))};
    else if (pick < 9) a = 32'($urandom_range(DEPTH*4, 4095));
    else               a = $urandom;
    xfer(d, 1'($urandom), a, $urandom, 4'($urandom), scramble, rd, e, l);
  endtask

  // ---------------- scoreboard: every cycle, both instances ----------------
  always @(negedge pclk) begin
    for (int d = 0; d < 2; d++) begin
      logic        rdy, err;
      logic [31:0] rd;
      get_out(d, rdy, err, rd);
      if (presetn && cyc == exp_cyc[d]) begin
        chk($sformatf("dut%0d_resp_pready", d), 32'(rdy), 32'd1);
        chk($sformatf("dut%0d_resp_pslverr", d), 32'(err), 32'(exp_err[d]));
        if (exp_isrd[d]) chk($sformatf("dut%0d_resp_prdata", d), rd, exp_data[d]);
      end else begin
        chk($sformatf("dut%0d_idle_pready", d), 32'(rdy), 32'd0);
        chk($sformatf("dut%0d_idle_pslverr", d), 32'(err), 32'd0);
        chk($sformatf("dut%0d_idle_prdata", d), rd, 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd, v;
    logic        e;
    int          l;

    set_req(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    set_req(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    chk("dut0_reset_state", 32'(st0), 32'(S_IDLE));
    chk("dut1_reset_state", 32'(st1), 32'(S_IDLE));
    @(posedge pclk); #1;
    presetn = 1'b1;

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < DEPTH; i++) xfer(d, 1'b1, 32'(i*4), $urandom, 4'hF, 1'b0, rd, e, l);
      go_idle(d);
    end

    // zero-wait instance: directed cases
    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, rd, e, l);
    chk("wr10_latency", 32'(l), 32'd1);
    chk("wr10_pslverr", 32'(e), 32'd0);
    xfer(0, 1'b0, 32'h10, 32'd0, 4'hF, 1'b0, rd, e, l);
    chk("rd10_prdata", rd, 32'hDEADBEEF);
    chk("rd10_latency", 32'(l), 32'd1);
    xfer(0, 1'b1, 32'h0, 32'h12345678, 4'hF, 1'b0, rd, e, l);
    xfer(0, 1'b0, 32'h100, 32'd0, 4'hF, 1'b0, rd, e, l);
    chk("rd100_pslverr", 32'(e), 32'd1);
    chk("rd100_prdata", rd, 32'd0);
    xfer(0, 1'b0, 32'h0, 32'd0, 4'hF, 1'b0, rd, e, l);
    chk("rd0_after_oob", rd, 32'h12345678);
    xfer(0, 1'b1, 32'h2, 32'hFFFFFFFF, 4'hF, 1'b0, rd, e, l);
    chk("wr02_pslverr", 32'(e), 32'd1);
    xfer(0, 1'b0, 32'h0, 32'd0, 4'hF, 1'b0, rd, e, l);
    chk("rd0_after_unaligned", rd, 32'h12345678);
    xfer(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, rd, e, l);
    xfer(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, rd, e, l);
    xfer(0, 1'b0, 32'h20, 32'd0, 4'hF, 1'b0, rd, e, l);
`ifdef APB_RAM_PSTRB_EN
    v = 32'h11BB33DD;
`else
    v = 32'hAABBCCDD;
`endif
    exp_q.push_back(v);
    chk("strobe_merge", rd, exp_q.pop_front());
    repeat (200) rand_xfer(0, 1'b0);
    go_idle(0);

    // three-wait instance: latency, bus changes during WAIT, abort, reset
    xfer(1, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, 1'b1, rd, e, l);
    chk("w3_wr_latency", 32'(l), 32'd4);
    xfer(1, 1'b0, 32'h30, 32'd0, 4'hF, 1'b1, rd, e, l);
    chk("w3_rd_latency", 32'(l), 32'd4);
    chk("w3_rd_prdata", rd, 32'hCAFEF00D);
    go_idle(1);

    @(posedge pclk); #1;
    set_req(1, 1'b1, 1'b0, 1'b1, 32'h30, 32'h99999999, 4'hF);
    @(posedge pclk); #1;
    set_req(1, 1'b1, 1'b1, 1'b1, 32'h30, 32'h99999999, 4'hF);
    exp_cyc[1] = -1;
    @(posedge pclk); #1;
    set_req(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    repeat (3) @(negedge pclk);
    chk("abort_state", 32'(st1), 32'(S_IDLE));
    xfer(1, 1'b0, 32'h30, 32'd0, 4'hF, 1'b0, rd, e, l);
    chk("abort_no_write", rd, 32'hCAFEF00D);
    go_idle(1);

    @(posedge pclk); #1;
    set_req(1, 1'b1, 1'b0, 1'b1, 32'h30, 32'h77777777, 4'hF);
    @(posedge pclk); #1;
    set_req(1, 1'b1, 1'b1, 1'b1, 32'h30, 32'h77777777, 4'hF);
    exp_cyc[1] = -1;
    repeat (2) @(posedge pclk);
    #1;
    presetn = 1'b0;
    set_req(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(negedge pclk);
    chk("rst_mid_state", 32'(st1), 32'(S_IDLE));
    @(posedge pclk); #1;
    presetn = 1'b1;
    xfer(1, 1'b0, 32'h30, 32'd0, 4'hF, 1'b0, rd, e, l);
    chk("rst_no_write", rd, 32'hCAFEF00D);
    repeat (150) rand_xfer(1, 1'($urandom));
    go_idle(1);
    repeat (4) @(posedge pclk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
